// File: rtl/ripple_carry_adder_8bit_pkg.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder_8bit_pkg
//   Shared constants and types for the 8-bit ripple-carry adder used in the
//   single-precision multiplier datapath (exponent addition).
//
//   ADDER_WIDTH : operand / sum width of the adder
//   operand_t   : unsigned operand vector of ADDER_WIDTH bits
// -----------------------------------------------------------------------------
package ripple_carry_adder_8bit_pkg;

    localparam int ADDER_WIDTH = 8;

    typedef logic [ADDER_WIDTH-1:0] operand_t;

endpackage : ripple_carry_adder_8bit_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One bit of the ripple chain. Purely combinational.
//
//   Ports:
//     a, b  : operand bits
//     cin   : carry in from the next-lower stage
//     s     : sum bit
//     cout  : carry out to the next-higher stage
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic prop;

    // Propagate term is shared by the sum and the carry expressions.
    assign prop = a ^ b;
    assign s    = prop ^ cin;
    assign cout = (a & b) | (cin & prop);

endmodule : full_adder

// File: rtl/ripple_carry_adder_8bit.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder_8bit
//   Unsigned ripple-carry adder with no carry-in. Provides a zero-latency
//   combinational result and a one-cycle registered copy with a valid flag
//   for pipelined use.
//
//   Parameters:
//     WIDTH       : operand and sum width (default ADDER_WIDTH = 8)
//
//   Ports:
//     clk         : rising-edge clock
//     rst         : synchronous, active-high reset (registered path only)
//     a, b        : unsigned operands
//     in_valid    : qualifies a/b for the registered path
//     sum         : combinational (a + b) mod 2^WIDTH
//     carry_out   : combinational carry out of the MSB stage
//     sum_q       : registered sum (loaded only when in_valid)
//     carry_out_q : registered carry out (loaded only when in_valid)
//     out_valid   : in_valid delayed by one cycle
// -----------------------------------------------------------------------------
module ripple_carry_adder_8bit
    import ripple_carry_adder_8bit_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_out_q,
    output logic             out_valid
);

    // -------------------------------------------------------------------------
    // Combinational ripple chain: carry[i] is the carry into stage i.
    // -------------------------------------------------------------------------
    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
        full_adder u_fa (
            .a    (a[gi]),
            .b    (b[gi]),
            .cin  (carry[gi]),
            .s    (sum[gi]),
            .cout (carry[gi+1])
        );
    end

    assign carry_out = carry[WIDTH];

    // -------------------------------------------------------------------------
    // Registered copy. The result registers only load on a valid transaction
    // so downstream logic can keep reading the last good result while idle.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sum_d;
    logic             carry_out_d;
    logic             out_valid_d;
    logic             out_valid_q;

    always_comb begin
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d       = sum;
            carry_out_d = carry_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

endmodule : ripple_carry_adder_8bit

// File: tb/tb_ripple_carry_adder_8bit.sv
// -----------------------------------------------------------------------------
// tb_ripple_carry_adder_8bit
//   Self-checking bench for ripple_carry_adder_8bit. Expected values come from
//   plain integer arithmetic on the operands plus a small model of the
//   registered path (load on valid, hold otherwise, clear on reset).
// -----------------------------------------------------------------------------
module tb_ripple_carry_adder_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_valid;
    logic [7:0] sum;
    logic       carry_out;
    logic [7:0] sum_q;
    logic       carry_out_q;
    logic       out_valid;

    int vectors;
    int miscompares;

    // Reference model of the registered outputs
    int   exp_sum_q;
    int   exp_cout_q;
    int   exp_valid;

    ripple_carry_adder_8bit dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .in_valid    (in_valid),
        .sum         (sum),
        .carry_out   (carry_out),
        .sum_q       (sum_q),
        .carry_out_q (carry_out_q),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance one rising edge, update the model with the inputs that were
    // sampled at that edge, then return 1 ns later (away from the edge).
    task automatic tick();
        int total;
        @(posedge clk);
        total = int'(a) + int'(b);
        if (rst) begin
            exp_sum_q  = 0;
            exp_cout_q = 0;
            exp_valid  = 0;
        end else begin
            exp_valid = int'(in_valid);
            if (in_valid) begin
                exp_sum_q  = total % 256;
                exp_cout_q = (total >= 256) ? 1 : 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        #5;
        vectors++;
        if (sum_q !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_sum_q: got %h expected 00", sum_q);
        end
        vectors++;
        if (carry_out_q !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_carry_out_q: got %b expected 0", carry_out_q);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if ({carry_out, sum} !== 9'h000) begin
            miscompares++;
            $display("FAIL reset_comb_zero: got %h expected 000", {carry_out, sum});
        end
        $display("test_reset: sum_q=%h carry_out_q=%b out_valid=%b", sum_q, carry_out_q, out_valid);
    endtask

    task automatic test_directed();
        // {a, b, expected {carry, sum}} straight from the arithmetic boundaries
        logic [7:0] ta [5] = '{8'h89, 8'hFF, 8'h05, 8'h00, 8'hFF};
        logic [7:0] tb_ [5] = '{8'h83, 8'h01, 8'h0A, 8'h00, 8'hFF};
        logic [8:0] te [5] = '{9'h10C, 9'h100, 9'h00F, 9'h000, 9'h1FE};
        for (int i = 0; i < 5; i++) begin
            a = ta[i]; b = tb_[i]; in_valid = 1'b1;
            #5;
            vectors++;
            if ({carry_out, sum} !== te[i]) begin
                miscompares++;
                $display("FAIL directed_comb[%0d]: %h+%h got %h expected %h", i, a, b, {carry_out, sum}, te[i]);
            end
            tick();
            vectors++;
            if ({out_valid, carry_out_q, sum_q} !== {1'b1, te[i]}) begin
                miscompares++;
                $display("FAIL directed_reg[%0d]: got v=%b %h expected v=1 %h", i, out_valid, {carry_out_q, sum_q}, te[i]);
            end
            $display("test_directed: a=%h b=%h sum=%h cout=%b sum_q=%h cout_q=%b v=%b",
                     a, b, sum, carry_out, sum_q, carry_out_q, out_valid);
        end
    endtask

    task automatic test_hold();
        // Previous transaction was FF+FF, so the registers must keep FE / 1.
        in_valid = 1'b0; a = 8'h10; b = 8'h20;
        #5;
        vectors++;
        if ({carry_out, sum} !== 9'h030) begin
            miscompares++;
            $display("FAIL hold_comb: got %h expected 030", {carry_out, sum});
        end
        tick();
        tick();
        vectors++;
        if ({carry_out_q, sum_q} !== 9'h1FE) begin
            miscompares++;
            $display("FAIL hold_reg: got %h expected 1fe", {carry_out_q, sum_q});
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_out_valid: got %b expected 0", out_valid);
        end
        $display("test_hold: sum=%h sum_q=%h cout_q=%b v=%b", sum, sum_q, carry_out_q, out_valid);
    endtask

    task automatic test_reset_midstream();
        a = 8'h89; b = 8'h83; in_valid = 1'b1; rst = 1'b1;
        #5;
        vectors++;
        if ({carry_out, sum} !== 9'h10C) begin
            miscompares++;
            $display("FAIL midrst_comb_during: got %h expected 10c", {carry_out, sum});
        end
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #5;
        vectors++;
        if ({out_valid, carry_out_q, sum_q} !== 10'h000) begin
            miscompares++;
            $display("FAIL midrst_reg: got v=%b %h expected v=0 000", out_valid, {carry_out_q, sum_q});
        end
        vectors++;
        if ({carry_out, sum} !== 9'h10C) begin
            miscompares++;
            $display("FAIL midrst_comb_after: got %h expected 10c", {carry_out, sum});
        end
        $display("test_reset_midstream: sum=%h sum_q=%h cout_q=%b v=%b", sum, sum_q, carry_out_q, out_valid);
    endtask

    task automatic test_exhaustive();
        int errs = 0;
        int total;
        in_valid = 1'b0;
        tick();
        // Steps of 2 ns starting 1 ns after an edge never land on a clock edge.
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                a = 8'(i); b = 8'(j);
                #2;
                total = i + j;
                vectors++;
                if ({carry_out, sum} !== 9'(total)) begin
                    miscompares++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL exhaustive: %h+%h got %h expected %h", a, b, {carry_out, sum}, 9'(total));
                end
            end
        end
        $display("test_exhaustive: 65536 pairs swept, %0d errors", errs);
    endtask

    task automatic test_back_to_back();
        int total;
        int errs = 0;
        for (int n = 0; n < 2000; n++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            in_valid = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            #5;
            total = int'(a) + int'(b);
            vectors++;
            if ({carry_out, sum} !== 9'(total)) begin
                miscompares++;
                errs++;
                $display("FAIL b2b_comb[%0d]: %h+%h got %h expected %h", n, a, b, {carry_out, sum}, 9'(total));
            end
            tick();
            vectors++;
            if (out_valid !== 1'(exp_valid) || sum_q !== 8'(exp_sum_q) || carry_out_q !== 1'(exp_cout_q)) begin
                miscompares++;
                errs++;
                $display("FAIL b2b_reg[%0d]: got v=%b c=%b s=%h expected v=%0d c=%0d s=%h",
                         n, out_valid, carry_out_q, sum_q, exp_valid, exp_cout_q, 8'(exp_sum_q));
            end
        end
        rst = 1'b0;
        $display("test_back_to_back: 2000 cycles, %0d errors", errs);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_sum_q   = 0;
        exp_cout_q  = 0;
        exp_valid   = 0;
        rst = 1'b0; a = 8'h00; b = 8'h00; in_valid = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_midstream();
        test_exhaustive();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ripple_carry_adder_8bit

// File: doc/ripple_carry_adder_8bit.md
Name: ripple_carry_adder_8bit

Overview:
- 8-bit unsigned ripple-carry adder used in the IEEE-754 single-precision multiplier datapath, e.g. exponent addition.
- Sum is built from a chain of 1-bit full adders; there is no carry-in.
- Provides a combinational result (zero latency) and a registered copy with a valid flag, for pipelined use.
- One clock domain; synchronous active-high reset.

Parameters:
- WIDTH, 8, operand and sum width. Only 8 is required to be verified; the generate chain must be written in terms of WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- in_valid  input  1  qualifies a/b for the registered path
- sum  output  WIDTH  combinational (a+b) mod 2^WIDTH
- carry_out  output  1  combinational carry out of the MSB stage
- sum_q  output  WIDTH  registered sum
- carry_out_q  output  1  registered carry_out
- out_valid  output  1  registered in_valid

Behaviour:
- Combinational path:
  - {carry_out, sum} = a + b, computed with exact (WIDTH+1)-bit unsigned arithmetic.
  - Stage 0 carry-in is tied to 0. Stage i carry-in is the carry-out of stage i-1. carry_out is the carry-out of stage WIDTH-1.
  - Stage i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)).
  - sum and carry_out do not depend on clk, rst or in_valid. They must be settled well within 10 ns of an input change.
- Registered path:
  - Latency is 1 cycle.
  - On a rising edge with rst=1: sum_q = 0, carry_out_q = 0, out_valid = 0.
  - Otherwise, out_valid <= in_valid on every edge.
  - When in_valid=1: sum_q <= sum and carry_out_q <= carry_out.
  - When in_valid=0: sum_q and carry_out_q hold their previous values.
- Reset mid-stream:
  - A transaction presented in the same cycle as rst=1 is dropped; out_valid is 0 on the next cycle.
  - The combinational outputs are unaffected by reset.
- Boundaries:
  - 0+0 gives sum 0, carry 0.
  - 0xFF+0x01 wraps to sum 0x00 with carry 1.
  - 0xFF+0xFF gives sum 0xFE, carry 1.
  - Carry must propagate through all 8 stages.
- No X propagation on outputs after the first reset edge, provided a, b and in_valid are known.

Decomposition:
- Shared package: ADDER_WIDTH = 8 constant, plus typedef of the WIDTH-bit operand vector.
- One sub-module, full_adder: inputs a, b, cin; outputs s, cout; purely combinational.
- Instantiate it WIDTH times in a generate loop. The top level adds the carry chain wiring and the output registers.

Test Plan:
- a=0x89, b=0x83 -> sum=0x0C, carry_out=1 after 10 ns. With in_valid=1, one clock later sum_q=0x0C, carry_out_q=1, out_valid=1.
- a=0xFF, b=0x01 -> sum=0x00, carry_out=1, confirming the full 8-stage ripple. sum_q=0x00, carry_out_q=1 after one edge.
- a=0x05, b=0x0A -> sum=0x0F, carry_out=0. Then a=0x00, b=0x00 -> sum=0x00, carry_out=0.
- Hold in_valid=0 while a/b change to 0x10/0x20 -> sum=0x30 combinationally. sum_q and carry_out_q keep their prior values; out_valid=0.
- Assert rst=1 for one edge with in_valid=1 -> sum_q=0, carry_out_q=0, out_valid=0 next cycle. Combinational sum still equals a+b.
- Exhaustive sweep of all 65536 (a,b) pairs -> {carry_out, sum} == a+b in every case. With in_valid=1, the registered outputs match the previous cycle's result.
